// File: rtl/pipelined_ripple_adder_n_if.sv
// Operand/result handshake bundle for pipelined_ripple_adder_n.
// The ovf signal exists only when ADD_PIPE_OVF_EN is defined.
interface pipelined_ripple_adder_n_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] s;
    logic         cout;
`ifdef ADD_PIPE_OVF_EN
    logic         ovf;
`endif

    // Producer/consumer side: drives operands and result backpressure
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout
`ifdef ADD_PIPE_OVF_EN
        , input ovf
`endif
    );

    // Adder side
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout
`ifdef ADD_PIPE_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/pipelined_ripple_adder_n.sv
// N-bit adder/subtractor split into SEG-bit ripple segments, one per stage.
// Each stage resolves one segment, registers its carry, forwards the still
// unused upper operand bits (skew) and the already finished lower sum bits
// (de-skew), so a full result leaves the last stage every clock.
// The whole pipeline stalls together when the output is held.
// Optional macro ADD_PIPE_OVF_EN adds the signed overflow output ovf.
module pipelined_ripple_adder_n #(
    parameter int N   = 16,
    parameter int SEG = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    pipelined_ripple_adder_n_if.slave bus
);
    localparam int STAGES = (SEG > 0) ? (N / SEG) : 1;

    if (SEG < 1 || N < SEG || (N % SEG) != 0) begin : param_check_g
        $error("pipelined_ripple_adder_n: N must be a non-zero multiple of SEG");
    end

    logic adv;
    logic in_ready;
    logic init_d;
    logic init_q;

    // Input side opens only on the first clock after reset has been released
    always_comb begin
        init_d = 1'b1;
    end

    // Reset-release flag, cleared asynchronously and set synchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_q <= 1'b0;
        end else begin
            init_q <= init_d;
        end
    end

    // Global advance: every stage moves unless a held result blocks the exit
    always_comb begin
        adv      = ~stage_g[STAGES-1].v_q | bus.out_ready;
        in_ready = adv & init_q;
    end

    for (genvar k = 0; k < STAGES; k++) begin : stage_g
        localparam int W_OP = N - k * SEG;
        localparam int W_LO = k * SEG;

        logic [W_OP-1:0]       a_i;
        logic [W_OP-1:0]       b_i;
        logic                  c_i;
        logic                  v_i;
        logic [SEG:0]          seg_sum;
        logic [W_LO+SEG-1:0]   s_d;
        logic [W_LO+SEG-1:0]   s_q;
        logic                  c_d;
        logic                  c_q;
        logic                  v_d;
        logic                  v_q;

        if (k == 0) begin : src_g
            // Capture: apply add/sub mode (invert b, force carry-in) on entry
            always_comb begin
                a_i = bus.a;
                b_i = bus.sub ? ~bus.b : bus.b;
                c_i = bus.sub ? 1'b1 : bus.cin;
                v_i = bus.in_valid & in_ready;
            end

            // First segment starts the de-skewed sum
            always_comb begin
                s_d = seg_sum[SEG-1:0];
            end
        end else begin : src_g
            // Take the skewed operands and carry from the previous stage
            always_comb begin
                a_i = stage_g[k-1].op_g.a_q;
                b_i = stage_g[k-1].op_g.b_q;
                c_i = stage_g[k-1].c_q;
                v_i = stage_g[k-1].v_q;
            end

            // Append this segment above the sum bits finished upstream
            always_comb begin
                s_d = {seg_sum[SEG-1:0], stage_g[k-1].s_q};
            end
        end

        // Ripple-add the lowest remaining segment
        always_comb begin
            seg_sum = {1'b0, a_i[SEG-1:0]} + {1'b0, b_i[SEG-1:0]} + {{SEG{1'b0}}, c_i};
            c_d     = seg_sum[SEG];
            v_d     = v_i;
        end

        // Stage valid, carry and partial sum; frozen while stalled
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_d;
                c_q <= c_d;
                s_q <= s_d;
            end
        end

        if (k < STAGES - 1) begin : op_g
            logic [W_OP-SEG-1:0] a_d;
            logic [W_OP-SEG-1:0] a_q;
            logic [W_OP-SEG-1:0] b_d;
            logic [W_OP-SEG-1:0] b_q;

            // Forward only the operand bits later stages still need
            always_comb begin
                a_d = a_i[W_OP-1:SEG];
                b_d = b_i[W_OP-1:SEG];
            end

            // Operand skew registers
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

`ifdef ADD_PIPE_OVF_EN
        if (k == STAGES - 1) begin : ovf_g
            logic ovf_d;
            logic ovf_q;

            // Carry into the MSB equals a^b^s there, so ovf = a^b^s^cout at bit N-1
            always_comb begin
                ovf_d = a_i[W_OP-1] ^ b_i[W_OP-1] ^ seg_sum[SEG-1] ^ seg_sum[SEG];
            end

            // Overflow travels with the result it belongs to
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= ovf_d;
                end
            end
        end
`endif
    end

    // Last stage drives the result side of the bus
    always_comb begin
        bus.in_ready  = in_ready;
        bus.out_valid = stage_g[STAGES-1].v_q;
        bus.s         = stage_g[STAGES-1].s_q;
        bus.cout      = stage_g[STAGES-1].c_q;
`ifdef ADD_PIPE_OVF_EN
        bus.ovf       = stage_g[STAGES-1].ovf_g.ovf_q;
`endif
    end
endmodule

// File: tb/tb_pipelined_ripple_adder_n.sv
// Testbench for pipelined_ripple_adder_n (N=16, SEG=4, four stages).
// Checks ovf as well when ADD_PIPE_OVF_EN is defined.
module tb_pipelined_ripple_adder_n;
    localparam int N      = 16;
    localparam int SEG    = 4;
    localparam int STAGES = N / SEG;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] exp_s;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    int   test_count = 0;
    int   fail_count = 0;
    int   run_len    = 0;
    int   max_run    = 0;
    int   out_beats  = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[12];

    pipelined_ripple_adder_n_if #(.N(N)) bus ();

    pipelined_ripple_adder_n #(
        .N   (N),
        .SEG (SEG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Hang guard
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, fail_count=%0d", fail_count);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Independent reference: plain integer add/subtract with range-based overflow
    function automatic vec_t make_vec(input logic [15:0] a, input logic [15:0] b,
                                      input logic cin, input logic sub);
        vec_t        v;
        logic [16:0] t;
        int          sa;
        int          sb;
        int          r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            r          = sa - sb;
            t          = {1'b0, a} - {1'b0, b};
            v.exp_cout = ~t[16];
        end else begin
            r          = sa + sb + int'(cin);
            t          = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            v.exp_cout = t[16];
        end
        v.a       = a;
        v.b       = b;
        v.cin     = cin;
        v.sub     = sub;
        v.exp_s   = t[15:0];
        v.exp_ovf = (r > 32767) || (r < -32768);
        return v;
    endfunction

    // Present one beat, wait (bounded) for acceptance, queue its expectation
    task automatic applyStimulus(input vec_t v);
        int   guard;
        exp_t e;
        guard        = 0;
        bus.in_valid = 1'b1;
        bus.a        = v.a;
        bus.b        = v.b;
        bus.cin      = v.cin;
        bus.sub      = v.sub;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) break;
            @(posedge clk);
            #1;
            guard++;
            if (guard > 50) begin
                checkOutput("accept_timeout", guard, 0);
                bus.in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        e.s    = v.exp_s;
        e.cout = v.exp_cout;
        e.ovf  = v.exp_ovf;
        exp_q.push_back(e);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) for every queued beat to come out
    task automatic waitDrain(input string name, input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every emitted beat must match the oldest expectation
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            out_beats++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_beat", bus.out_valid, 0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("beat_s", bus.s, mon_e.s);
                checkOutput("beat_cout", bus.cout, mon_e.cout);
`ifdef ADD_PIPE_OVF_EN
                checkOutput("beat_ovf", bus.ovf, mon_e.ovf);
`endif
            end
        end else begin
            run_len = 0;
        end
    end

    initial begin
        int beats_before;
        vec_t rv;

        vecs[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[4]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[6]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[8]  = '{16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b1, 1'b0};
        vecs[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[10] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[11] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_s", bus.s, 0);
        checkOutput("rst_cout", bus.cout, 0);
`ifdef ADD_PIPE_OVF_EN
        checkOutput("rst_ovf", bus.ovf, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("in_ready_after_rst", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Single beat: result appears exactly STAGES cycles after acceptance
        applyStimulus(vecs[0]);
        for (int cyc = 1; cyc <= STAGES; cyc++) begin
            @(negedge clk);
            checkOutput($sformatf("latency_c%0d", cyc), bus.out_valid, (cyc == STAGES) ? 1 : 0);
        end
        @(posedge clk);
        #1;

        // Directed table, streamed back-to-back
        for (int i = 1; i < 12; i++) begin
            applyStimulus(vecs[i]);
        end
        waitDrain("drain_table", 20);

        // Random burst of 8: one result per cycle, in order
        max_run = 0;
        for (int i = 0; i < 8; i++) begin
            rv = make_vec(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
            applyStimulus(rv);
        end
        waitDrain("drain_burst", 20);
        checkOutput("burst_run", max_run, 8);

        // Backpressure: fill with output held, verify stall, then release
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i]);
        end
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            checkOutput("stall_in_ready", bus.in_ready, 0);
            checkOutput("stall_out_valid", bus.out_valid, 1);
            checkOutput("stall_s_held", bus.s, 16'h0100);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        waitDrain("drain_backpressure", 20);

        // Reset mid-flight: in-flight beats are discarded
        for (int i = 5; i < 9; i++) begin
            applyStimulus(vecs[i]);
        end
        checkOutput("pre_reset_out_valid", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_out_valid", bus.out_valid, 0);
        checkOutput("async_rst_s", bus.s, 0);
        checkOutput("async_rst_cout", bus.cout, 0);
        exp_q.delete();
        beats_before = out_beats;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("no_stale_beats", out_beats - beats_before, 0);

        // Pipeline usable again after the mid-flight reset
        @(posedge clk);
        #1;
        applyStimulus(vecs[11]);
        waitDrain("drain_after_reset", 20);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end
endmodule
